datapath_sched: RTL

Two-requester scheduler that shares the 4-bit add/convert datapath (load, a, b, Cin, select → Q[9:0]) between two client ports. It arbitrates requests, latches the winner's operands, drives the datapath's load and operand inputs for one issue cycle, and waits a fixed latency. It then captures Q and returns it to the winning client with an ID and a one-cycle valid pulse. It sits between the datapath and the control logic above it, and is the only driver of the datapath inputs.

---
 rtl/datapath_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/datapath_sched.sv
// Two-requester scheduler that issues one operation at a time to the shared add/convert datapath.
// Arbitration is round-robin when DATAPATH_SCHED_RR_EN is defined, fixed priority (requester 0) otherwise.
module datapath_sched #(
    parameter int DP_LAT = 2   // load-to-Q latency in cycles, 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       cin0,
    input  logic       sel0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       cin1,
    input  logic       sel1,
    output logic       gnt1,
    output logic       dp_load,
    output logic [3:0] dp_a,
    output logic [3:0] dp_b,
    output logic       dp_cin,
    output logic       dp_select,
    input  logic [9:0] dp_q,
    output logic       res_valid,
    output logic       res_id,
    output logic [9:0] res_q,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_win;
    logic       w_win;

`ifdef DATAPATH_SCHED_RR_EN
    logic       r_last;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_win = (req0 && req1) ? ~r_last : req1;
    end
`else
    always_comb begin
        w_win = ~req0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_win     <= 1'b0;
`ifdef DATAPATH_SCHED_RR_EN
            r_last    <= 1'b1;
`endif
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            dp_load   <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_cin    <= 1'b0;
            dp_select <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_q     <= '0;
            busy      <= 1'b0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            dp_load   <= 1'b0;
            res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_win     <= w_win;
`ifdef DATAPATH_SCHED_RR_EN
                        r_last    <= w_win;
`endif
                        dp_a      <= w_win ? a1 : a0;
                        dp_b      <= w_win ? b1 : b0;
                        dp_cin    <= w_win ? cin1 : cin0;
                        dp_select <= w_win ? sel1 : sel0;
                        gnt0      <= ~w_win;
                        gnt1      <= w_win;
                        dp_load   <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= 4'(DP_LAT - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Counter hits zero on the edge where Q is valid.
                    if (r_cnt == 4'd0) begin
                        res_q     <= dp_q;
                        res_id    <= r_win;
                        res_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
